// File: rtl/uart_pkg.sv
// Shared UART package: data width, receive FIFO depth and pointer/count sizing helpers.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
package uart_pkg;

    localparam int UART_DATA_W     = 8;
    localparam int UART_FIFO_DEPTH = 16;

    // Pointer width for a power-of-two depth; never narrower than one bit.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy counter width; must be able to hold the value 'depth' itself.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Handshake bundle between uart_rx (writer), the receive FIFO and uart_tx (reader).
// Latency: n/a (wiring only).
// Backpressure: wr_valid_i/wr_ready_o on the write side, rd_valid_o/rd_ready_i on the read side.
interface uart_rx_fifo_if
    import uart_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W,
    parameter int DEPTH  = UART_FIFO_DEPTH
);

    logic [DATA_W-1:0]       wr_data_i;
    logic                    wr_valid_i;
    logic                    wr_ready_o;
    logic [DATA_W-1:0]       rd_data_o;
    logic                    rd_valid_o;
    logic                    rd_ready_i;
    logic                    flush_i;
    logic                    clr_ovf_i;
    logic [cnt_w(DEPTH)-1:0] count_o;
    logic                    afull_o;
    logic                    ovf_o;

    // The FIFO itself.
    modport slave (
        input  wr_data_i, wr_valid_i, rd_ready_i, flush_i, clr_ovf_i,
        output wr_ready_o, rd_data_o, rd_valid_o, count_o, afull_o, ovf_o
    );

    // The surrounding logic driving and draining the FIFO.
    modport master (
        output wr_data_i, wr_valid_i, rd_ready_i, flush_i, clr_ovf_i,
        input  wr_ready_o, rd_data_o, rd_valid_o, count_o, afull_o, ovf_o
    );

endinterface

// File: rtl/uart_fifo_mem.sv
// Storage array for the receive FIFO: synchronous write, asynchronous read at the read pointer.
// Latency: write visible on the read port after the writing edge; read is combinational from the address.
// Backpressure: none; the caller only asserts we_i for accepted writes.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W,
    parameter int DEPTH  = UART_FIFO_DEPTH
) (
    input  logic                    clk,
    input  logic                    we_i,
    input  logic [ptr_w(DEPTH)-1:0] waddr_i,
    input  logic [DATA_W-1:0]       wdata_i,
    input  logic [ptr_w(DEPTH)-1:0] raddr_i,
    output logic [DATA_W-1:0]       rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Contents are never reset; validity is tracked by the FIFO occupancy.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO between uart_rx and uart_tx with sticky overflow flag.
// Latency: a byte written at edge N is presented on rd_data_o after edge N; no input-to-output bypass.
// Backpressure: wr_ready_o drops when full; writes attempted while full are dropped and set ovf_o.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W    = UART_DATA_W,
    parameter int DEPTH     = UART_FIFO_DEPTH,
    parameter int AFULL_LVL = DEPTH - 4
) (
    input  logic          clk,
    input  logic          reset,
    uart_rx_fifo_if.slave bus
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(AFULL_LVL);

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              full, empty;
    logic              wr_acc, rd_acc, ovf_ev, mem_we;
    logic [DATA_W-1:0] mem_rdata;

    // Full/empty come from the registered count only, so neither handshake
    // input can reach wr_ready_o, rd_valid_o or count_o combinationally.
    assign full   = (count_q == FULL_CNT);
    assign empty  = (count_q == '0);
    assign wr_acc = bus.wr_valid_i & ~full  & ~reset;
    assign rd_acc = bus.rd_ready_i & ~empty & ~reset;
    // A full FIFO refuses the byte even if a read frees a slot this cycle.
    assign ovf_ev = bus.wr_valid_i & full & ~reset;
    // A write that lands in a flush cycle is discarded along with everything else.
    assign mem_we = wr_acc & ~bus.flush_i;

    // Next-state for pointers, occupancy and the sticky overflow flag.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (bus.flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Power-of-two depth: pointers wrap by natural overflow.
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
        // A fresh overflow beats a same-cycle clear.
        if (ovf_ev) begin
            ovf_d = 1'b1;
        end else if (bus.clr_ovf_i) begin
            ovf_d = 1'b0;
        end
    end

    // State registers with synchronous reset; storage itself is not reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    uart_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (wr_ptr_q),
        .wdata_i (bus.wr_data_i),
        .raddr_i (rd_ptr_q),
        .rdata_o (mem_rdata)
    );

    // Outputs are forced to zero while reset is held, even before the clearing edge.
    assign bus.wr_ready_o = ~reset & ~full;
    assign bus.rd_valid_o = ~reset & ~empty;
    assign bus.rd_data_o  = (~reset & ~empty) ? mem_rdata : '0;
    assign bus.count_o    = reset ? '0 : count_q;
    assign bus.afull_o    = ~reset & (count_q >= AFULL_CNT);
    assign bus.ovf_o      = ~reset & ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed scenarios then randomized traffic against a queue model.
// Latency: outputs checked 1 time unit after each rising edge.
// Backpressure: reader readiness randomized in phases to reach both full and empty.
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AFULL = DEPTH - 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    uart_rx_fifo_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus ();

    uart_rx_fifo #(
        .DATA_W    (DW),
        .DEPTH     (DEPTH),
        .AFULL_LVL (AFULL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Reference model: a plain queue of stored bytes plus the sticky flag.
    logic [DW-1:0] mdl_q [$];
    bit            mdl_ovf;
    int            n_cmp;
    int            n_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        if (reset) begin
            chk("rst_wr_ready", 32'(bus.wr_ready_o), 32'd0);
            chk("rst_rd_valid", 32'(bus.rd_valid_o), 32'd0);
            chk("rst_count",    32'(bus.count_o),    32'd0);
            chk("rst_afull",    32'(bus.afull_o),    32'd0);
            chk("rst_ovf",      32'(bus.ovf_o),      32'd0);
            chk("rst_rd_data",  32'(bus.rd_data_o),  32'd0);
        end else begin
            chk("count",    32'(bus.count_o),    32'(mdl_q.size()));
            chk("rd_valid", 32'(bus.rd_valid_o), 32'(mdl_q.size() > 0));
            chk("wr_ready", 32'(bus.wr_ready_o), 32'(mdl_q.size() < DEPTH));
            chk("afull",    32'(bus.afull_o),    32'(mdl_q.size() >= AFULL));
            chk("ovf",      32'(bus.ovf_o),      32'(mdl_ovf));
            if (mdl_q.size() > 0) begin
                chk("rd_data", 32'(bus.rd_data_o), 32'(mdl_q[0]));
            end
        end
    endtask

    // One clock: drive inputs, advance the model on the edge, then compare.
    task automatic step(input bit rst, input bit wv, input logic [DW-1:0] wd,
                        input bit rr, input bit fl, input bit co);
        bit full_now;
        bit wr_ok;
        bit rd_ok;
        reset          = rst;
        bus.wr_valid_i = wv;
        bus.wr_data_i  = wd;
        bus.rd_ready_i = rr;
        bus.flush_i    = fl;
        bus.clr_ovf_i  = co;
        @(posedge clk);
        if (rst) begin
            mdl_q.delete();
            mdl_ovf = 1'b0;
        end else begin
            full_now = (mdl_q.size() == DEPTH);
            wr_ok    = wv && !full_now;
            rd_ok    = rr && (mdl_q.size() > 0);
            if (fl) begin
                mdl_q.delete();
            end else begin
                if (rd_ok) void'(mdl_q.pop_front());
                if (wr_ok) mdl_q.push_back(wd);
            end
            if (wv && full_now) mdl_ovf = 1'b1;
            else if (co)        mdl_ovf = 1'b0;
        end
        #1;
        check_outputs();
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wr(input logic [DW-1:0] d);
        step(1'b0, 1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rd();
        step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        mdl_ovf = 1'b0;

        // Reset held for a few cycles: every output must read zero.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        chk("post_rst_wr_ready", 32'(bus.wr_ready_o), 32'd1);

        // Single byte fall-through and drain.
        wr(8'hA5);
        chk("a5_data",  32'(bus.rd_data_o),  32'h0A5);
        chk("a5_count", 32'(bus.count_o),    32'd1);
        rd();
        chk("a5_empty", 32'(bus.rd_valid_o), 32'd0);

        // Fill to full, then drain in order.
        for (int i = 0; i < DEPTH; i++) wr(8'(i));
        chk("full_wr_ready", 32'(bus.wr_ready_o), 32'd0);
        chk("full_count",    32'(bus.count_o),    32'd16);
        chk("full_afull",    32'(bus.afull_o),    32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            chk("fill_order", 32'(bus.rd_data_o), 32'(i));
            rd();
        end

        // Write while full with a same-cycle read: byte dropped, overflow set.
        for (int i = 0; i < DEPTH; i++) wr(8'(i));
        step(1'b0, 1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
        chk("ovf_set",   32'(bus.ovf_o),   32'd1);
        chk("ovf_count", 32'(bus.count_o), 32'd15);
        for (int i = 1; i < DEPTH; i++) begin
            chk("ovf_order", 32'(bus.rd_data_o), 32'(i));
            rd();
        end
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("ovf_clr", 32'(bus.ovf_o), 32'd0);

        // Overflow and clear in the same cycle: overflow wins.
        for (int i = 0; i < DEPTH; i++) wr(8'(8'h50 + i));
        step(1'b0, 1'b1, 8'h77, 1'b0, 1'b0, 1'b1);
        chk("ovf_vs_clr", 32'(bus.ovf_o), 32'd1);
        step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        chk("flush_cnt0", 32'(bus.count_o), 32'd0);

        // Streaming at occupancy 1 across several pointer wraps.
        wr(8'h80);
        for (int i = 1; i <= 40; i++) begin
            step(1'b0, 1'b1, 8'(8'h80 + i), 1'b1, 1'b0, 1'b0);
            chk("stream_data",  32'(bus.rd_data_o), 32'(8'(8'h80 + i)));
            chk("stream_count", 32'(bus.count_o),   32'd1);
        end
        rd();

        // Flush with a same-cycle write at count 7; next write becomes head.
        for (int i = 0; i < 7; i++) wr(8'(8'h30 + i));
        chk("pre_flush_count", 32'(bus.count_o), 32'd7);
        step(1'b0, 1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
        chk("flush_count", 32'(bus.count_o),    32'd0);
        chk("flush_valid", 32'(bus.rd_valid_o), 32'd0);
        wr(8'h42);
        chk("flush_head", 32'(bus.rd_data_o), 32'h042);
        rd();

        // Reset pulse mid-operation at count 5.
        for (int i = 0; i < 5; i++) wr(8'(8'h60 + i));
        step(1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
        chk("midrst_count", 32'(bus.count_o), 32'd0);
        wr(8'h5C);
        chk("midrst_head",  32'(bus.rd_data_o), 32'h05C);
        chk("midrst_count1", 32'(bus.count_o),  32'd1);

        // Randomized traffic in phases biased toward filling or draining.
        for (int i = 0; i < 1600; i++) begin
            int wp;
            int rp;
            case ((i / 160) % 4)
                0:       begin wp = 80; rp = 30; end
                1:       begin wp = 30; rp = 80; end
                2:       begin wp = 60; rp = 60; end
                default: begin wp = 95; rp = 10; end
            endcase
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 99) < wp,
                 8'($urandom),
                 $urandom_range(0, 99) < rp,
                 $urandom_range(0, 99) < 2,
                 $urandom_range(0, 99) < 5);
        end
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
